// File: rtl/mure_pkg.sv
// Shared types for the commit/itype stage: itype encoding, widths and the
// pipeline stage payload, plus the exception-patch helper.
package mure_pkg;

    localparam int unsigned NR_RETIRED = 2;
    localparam int unsigned XLEN       = 64;
    localparam int unsigned CAUSE_LEN  = 5;
    localparam int unsigned PRIV_LEN   = 2;
    localparam int unsigned ITYPE_LEN  = 3;

    localparam logic [ITYPE_LEN-1:0] ITYPE_NONE      = 3'd0;
    localparam logic [ITYPE_LEN-1:0] ITYPE_EXCEPTION = 3'd1;
    localparam logic [ITYPE_LEN-1:0] ITYPE_INTERRUPT = 3'd2;
    localparam logic [ITYPE_LEN-1:0] ITYPE_ERET      = 3'd3;
    localparam logic [ITYPE_LEN-1:0] ITYPE_NT_BRANCH = 3'd4;
    localparam logic [ITYPE_LEN-1:0] ITYPE_T_BRANCH  = 3'd5;
    localparam logic [ITYPE_LEN-1:0] ITYPE_UNINF_JMP = 3'd6;

    typedef struct packed {
        logic                                    valid;
        logic                                    patched;
        logic [NR_RETIRED-1:0]                   iretire;
        logic [NR_RETIRED-1:0]                   ilastsize;
        logic [NR_RETIRED-1:0][ITYPE_LEN-1:0]    itype;
        logic [NR_RETIRED-1:0][XLEN-1:0]         iaddr;
        logic [CAUSE_LEN-1:0]                    cause;
        logic [XLEN-1:0]                         tval;
        logic [PRIV_LEN-1:0]                     priv;
    } stage_entry_s;

    // Trap itype for a cause: MSB set marks an interrupt.
    function automatic logic [ITYPE_LEN-1:0] trap_itype(input logic [CAUSE_LEN-1:0] cause);
        return cause[CAUSE_LEN-1] ? ITYPE_INTERRUPT : ITYPE_EXCEPTION;
    endfunction

    // Attach a trap to the last instruction retired in the group.
    function automatic stage_entry_s patch_entry(input stage_entry_s         e,
                                                 input logic [CAUSE_LEN-1:0] cause,
                                                 input logic [XLEN-1:0]      tval);
        stage_entry_s p;
        logic         found;
        p     = e;
        found = 1'b0;
        for (int i = int'(NR_RETIRED) - 1; i >= 0; i--) begin
            if (!found && e.iretire[i]) begin
                p.itype[i] = trap_itype(cause);
                found      = 1'b1;
            end
        end
        p.cause   = cause;
        p.tval    = tval;
        p.patched = 1'b1;
        return p;
    endfunction

endpackage

// File: rtl/commit_itype_stage_itype_detector.sv
// Per-commit-port base itype classification (no trap information).
module itype_detector
    import mure_pkg::*;
(
    input  logic                 i_valid,
    input  logic                 i_is_branch,
    input  logic                 i_branch_taken,
    input  logic                 i_is_jump_uninf,
    input  logic                 i_eret,
    output logic [ITYPE_LEN-1:0] o_itype_c
);

    always_comb begin
        o_itype_c = ITYPE_NONE;
        if (!i_valid) begin
            o_itype_c = ITYPE_NONE;
        end else if (i_eret) begin
            o_itype_c = ITYPE_ERET;
        end else if (i_is_branch && i_branch_taken) begin
            o_itype_c = ITYPE_T_BRANCH;
        end else if (i_is_branch) begin
            o_itype_c = ITYPE_NT_BRANCH;
        end else if (i_is_jump_uninf) begin
            o_itype_c = ITYPE_UNINF_JMP;
        end
    end

endmodule

// File: rtl/commit_itype_stage.sv
// Captures commit ports, classifies itypes and attaches traps to the last
// retired instruction using a one-cycle hold stage (A) before the output stage (B).
module commit_itype_stage
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = NR_RETIRED
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NrRetiredInstr-1:0]                   valid_i,
    input  logic [NrRetiredInstr-1:0][XLEN-1:0]         pc_i,
    input  logic [NrRetiredInstr-1:0]                   compressed_i,
    input  logic [NrRetiredInstr-1:0]                   is_branch_i,
    input  logic [NrRetiredInstr-1:0]                   branch_taken_i,
    input  logic [NrRetiredInstr-1:0]                   is_jump_uninf_i,
    input  logic [NrRetiredInstr-1:0]                   eret_i,
    input  logic                                        ex_valid_i,
    input  logic [CAUSE_LEN-1:0]                        ex_cause_i,
    input  logic [XLEN-1:0]                             ex_tval_i,
    input  logic [XLEN-1:0]                             ex_pc_i,
    input  logic [PRIV_LEN-1:0]                         priv_i,
    output logic                                        valid_o,
    output logic [NrRetiredInstr-1:0]                   iretire_o,
    output logic [NrRetiredInstr-1:0]                   ilastsize_o,
    output logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]    itype_o,
    output logic [NrRetiredInstr-1:0][XLEN-1:0]         iaddr_o,
    output logic [CAUSE_LEN-1:0]                        cause_o,
    output logic [XLEN-1:0]                             tval_o,
    output logic [PRIV_LEN-1:0]                         priv_o
);

    logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0] w_base_itype;
    stage_entry_s                             w_cur;
    stage_entry_s                             w_exc;
    stage_entry_s                             w_a_next;
    stage_entry_s                             w_b_next;
    stage_entry_s                             r_a;
    stage_entry_s                             r_b;

    for (genvar g = 0; g < NrRetiredInstr; g++) begin : g_det
        itype_detector u_det (
            .i_valid         (valid_i[g]),
            .i_is_branch     (is_branch_i[g]),
            .i_branch_taken  (branch_taken_i[g]),
            .i_is_jump_uninf (is_jump_uninf_i[g]),
            .i_eret          (eret_i[g]),
            .o_itype_c       (w_base_itype[g])
        );
    end

    // Group retired this cycle, and the group used when a trap has nothing to attach to.
    always_comb begin
        w_cur       = '0;
        w_cur.valid = 1'b1;
        w_cur.priv  = priv_i;
        for (int i = 0; i < int'(NrRetiredInstr); i++) begin
            w_cur.iretire[i]   = valid_i[i];
            w_cur.ilastsize[i] = valid_i[i] & ~compressed_i[i];
            w_cur.itype[i]     = w_base_itype[i];
            w_cur.iaddr[i]     = valid_i[i] ? pc_i[i] : '0;
        end

        w_exc          = '0;
        w_exc.valid    = 1'b1;
        w_exc.patched  = 1'b1;
        w_exc.itype[0] = trap_itype(ex_cause_i);
        w_exc.iaddr[0] = ex_pc_i;
        w_exc.cause    = ex_cause_i;
        w_exc.tval     = ex_tval_i;
        w_exc.priv     = priv_i;
    end

    always_comb begin
        w_b_next = r_a;
        w_a_next = '0;
        if (|valid_i) begin
            w_a_next = ex_valid_i ? patch_entry(w_cur, ex_cause_i, ex_tval_i) : w_cur;
        end else if (ex_valid_i) begin
            // A trap one cycle after retirement belongs to the held group.
            if (r_a.valid && !r_a.patched) begin
                w_b_next = patch_entry(r_a, ex_cause_i, ex_tval_i);
            end else begin
                w_a_next = w_exc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a <= '0;
            r_b <= '0;
        end else begin
            r_a <= w_a_next;
            r_b <= w_b_next;
        end
    end

    assign valid_o     = r_b.valid;
    assign iretire_o   = r_b.iretire;
    assign ilastsize_o = r_b.ilastsize;
    assign itype_o     = r_b.itype;
    assign iaddr_o     = r_b.iaddr;
    assign cause_o     = r_b.cause;
    assign tval_o      = r_b.tval;
    assign priv_o      = r_b.priv;

endmodule
